ram2_arbiter: RTL and testbench

- Sequences the program SRAM (Ram2) and shares it between instruction fetch (IF) and MEM-stage loads/stores that target instruction space.
- Generates SRAM OE/WE/EN timing and the data-bus drive enable; the top level builds the Ram2Data tristate from the split data ports.
- Asserts stall_o so the pc and pipeline registers hold while a data access owns the SRAM.

---
 rtl/ram2_arbiter.sv | 81 ++++++++
 tb/tb_ram2_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ram2_arbiter.sv
// ram2_arbiter: sequences the program SRAM and shares it between instruction fetch and MEM-stage accesses
module ram2_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16,
  parameter int WE_PULSE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              stall_o,
  output logic [ADDR_W-1:0] Ram2Addr,
  output logic [DATA_W-1:0] Ram2Data_o,
  input  logic [DATA_W-1:0] Ram2Data_i,
  output logic              Ram2Data_oe,
  output logic              Ram2OE,
  output logic              Ram2WE,
  output logic              Ram2EN
);
  typedef enum logic [2:0] {IDLE, FETCH, DREAD, WSETUP, WPULSE, WHOLD, TURN} state_t;
  state_t state, state_n;
  logic [2:0] we_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic active;
  logic mem_req, accept;
  assign mem_req = mem_read | mem_write;
  assign accept = (state == IDLE || state == FETCH) && state_n != IDLE;
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= state_n;
  // a mem request during FETCH detours through IDLE so if_valid never overlaps a data access
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:    state_n = mem_done ? IDLE : mem_write ? WSETUP : mem_read ? DREAD : if_req ? FETCH : IDLE;
      FETCH:   state_n = (!mem_req && if_req) ? FETCH : IDLE;
      WSETUP:  state_n = WPULSE;
      WPULSE:  state_n = (we_cnt == 3'(WE_PULSE - 1)) ? WHOLD : WPULSE;
      WHOLD:   state_n = TURN;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    Ram2EN      = ~active;
    Ram2OE      = ~(state == FETCH || state == DREAD);
    Ram2WE      = state != WPULSE;
    Ram2Data_oe = state == WSETUP || state == WPULSE || state == WHOLD;
    Ram2Addr    = addr_q;
    Ram2Data_o  = wdata_q;
    stall_o     = rst & mem_req & ~mem_done;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      we_cnt    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      active    <= 1'b0;
      if_data   <= '0;
      if_valid  <= 1'b0;
      mem_rdata <= '0;
      mem_done  <= 1'b0;
    end else begin
      active   <= 1'b1;
      we_cnt   <= (state == WPULSE) ? we_cnt + 3'd1 : 3'd0;
      if (accept) addr_q <= (state_n == FETCH) ? if_addr : ADDR_W'(mem_addr);
      if (accept && state_n == WSETUP) wdata_q <= mem_wdata;
      if_valid <= state == FETCH;
      if (state == FETCH) if_data <= Ram2Data_i;
      mem_done <= state == DREAD || state_n == WHOLD;
      if (state == DREAD) mem_rdata <= Ram2Data_i;
    end
endmodule

// File: tb/tb_ram2_arbiter.sv
// tb_ram2_arbiter: directed checks of fetch, load, store, collision and reset behaviour against an SRAM model
module tb_ram2_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [17:0] if_addr = '0;
  logic [15:0] if_data;
  logic        if_valid;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b1;
  logic [15:0] mem_addr = '0;
  logic [15:0] mem_wdata = '0;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        stall_o;
  logic [17:0] Ram2Addr;
  logic [15:0] Ram2Data_o;
  logic [15:0] Ram2Data_i;
  logic        Ram2Data_oe, Ram2OE, Ram2WE, Ram2EN;
  int errors = 0;
  int checks = 0;
  int done_cnt;
  bit [15:0] sram [256];
  bit        written [256];

  ram2_arbiter #(.ADDR_W(18), .DATA_W(16), .WE_PULSE(2)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_valid(if_valid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .stall_o(stall_o), .Ram2Addr(Ram2Addr),
    .Ram2Data_o(Ram2Data_o), .Ram2Data_i(Ram2Data_i), .Ram2Data_oe(Ram2Data_oe),
    .Ram2OE(Ram2OE), .Ram2WE(Ram2WE), .Ram2EN(Ram2EN)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [7:0] a);
    return a == 8'h10 ? 16'hABCD : a == 8'h80 ? 16'h5A5A : {8'h10, a};
  endfunction

  assign Ram2Data_i = (!Ram2EN && !Ram2OE) ?
    (written[Ram2Addr[7:0]] ? sram[Ram2Addr[7:0]] : init_val(Ram2Addr[7:0])) : 16'h0000;

  always @(posedge clk)
    if (!Ram2EN && !Ram2WE) begin
      sram[Ram2Addr[7:0]]    <= Ram2Data_o;
      written[Ram2Addr[7:0]] <= 1'b1;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // bus contention: the SRAM must never drive while the top level drives
  always @(negedge clk)
    if (Ram2Data_oe === 1'b1) chk("oe_conflict", {31'b0, Ram2OE}, 32'd1);

  initial begin
    #1;
    tick;
    tick;
    chk("rst_en", Ram2EN, 1);
    chk("rst_oe", Ram2OE, 1);
    chk("rst_we", Ram2WE, 1);
    chk("rst_doe", Ram2Data_oe, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_pulses", {if_valid, mem_done}, 0);
    chk("rst_addr", Ram2Addr, 0);
    rst = 1'b1;
    mem_write = 1'b0;
    tick;
    chk("run_en", Ram2EN, 0);
    chk("idle_oe", Ram2OE, 1);
    // single fetch
    if_req = 1'b1;
    if_addr = 18'h00010;
    #1;
    chk("f_stall", stall_o, 0);
    tick;
    if_req = 1'b0;
    chk("f_oe", Ram2OE, 0);
    chk("f_addr", Ram2Addr, 18'h00010);
    chk("f_valid0", if_valid, 0);
    tick;
    chk("f_valid", if_valid, 1);
    chk("f_data", if_data, 16'hABCD);
    chk("f_oe_off", Ram2OE, 1);
    tick;
    chk("f_valid_end", if_valid, 0);
    // streaming fetch
    if_req = 1'b1;
    if_addr = 18'h0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (i < 3) if_addr = 18'(i + 1);
      else if_req = 1'b0;
      chk($sformatf("s_valid%0d", i), if_valid, i > 0 ? 1 : 0);
      if (i > 0) chk($sformatf("s_data%0d", i), if_data, 32'h1000 + 32'(i - 1));
    end
    tick;
    chk("s_valid_end", if_valid, 0);
    // write
    mem_write = 1'b1;
    mem_addr = 16'h0040;
    mem_wdata = 16'h1234;
    #1;
    chk("w_stall_req", stall_o, 1);
    tick;
    chk("w_setup_doe", Ram2Data_oe, 1);
    chk("w_setup_we", Ram2WE, 1);
    chk("w_setup_oe", Ram2OE, 1);
    chk("w_setup_addr", Ram2Addr, 18'h00040);
    chk("w_setup_data", Ram2Data_o, 16'h1234);
    chk("w_setup_stall", stall_o, 1);
    tick;
    chk("w_pulse1_we", Ram2WE, 0);
    chk("w_pulse1_done", mem_done, 0);
    tick;
    chk("w_pulse2_we", Ram2WE, 0);
    chk("w_pulse2_doe", Ram2Data_oe, 1);
    tick;
    chk("w_hold_we", Ram2WE, 1);
    chk("w_hold_doe", Ram2Data_oe, 1);
    chk("w_hold_done", mem_done, 1);
    chk("w_hold_stall", stall_o, 0);
    mem_write = 1'b0;
    tick;
    chk("w_turn_doe", Ram2Data_oe, 0);
    chk("w_turn_oe", Ram2OE, 1);
    chk("w_turn_done", mem_done, 0);
    chk("w_model", sram[8'h40], 16'h1234);
    tick;
    // collision: load arrives while a fetch is in flight
    if_req = 1'b1;
    if_addr = 18'h00010;
    tick;
    if_req = 1'b0;
    mem_read = 1'b1;
    mem_addr = 16'h0080;
    #1;
    chk("c_stall_fetch", stall_o, 1);
    chk("c_fetch_addr", Ram2Addr, 18'h00010);
    tick;
    chk("c_valid", if_valid, 1);
    chk("c_data", if_data, 16'hABCD);
    chk("c_stall_wait", stall_o, 1);
    tick;
    chk("c_dread_oe", Ram2OE, 0);
    chk("c_dread_addr", Ram2Addr, 18'h00080);
    chk("c_dread_valid", if_valid, 0);
    chk("c_dread_stall", stall_o, 1);
    tick;
    chk("c_done", mem_done, 1);
    chk("c_rdata", mem_rdata, 16'h5A5A);
    chk("c_stall_done", stall_o, 0);
    tick;
    chk("c_no_reissue_oe", Ram2OE, 1);
    chk("c_no_reissue_done", mem_done, 0);
    mem_read = 1'b0;
    tick;
    // read and write together: write wins, one completion
    mem_read = 1'b1;
    mem_write = 1'b1;
    mem_addr = 16'h0050;
    mem_wdata = 16'h7777;
    tick;
    chk("rw_write_first", Ram2Data_oe, 1);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (mem_done) begin
        done_cnt++;
        mem_read = 1'b0;
        mem_write = 1'b0;
      end
    end
    chk("rw_done_once", done_cnt, 1);
    chk("rw_model", sram[8'h50], 16'h7777);
    // reset during the WE pulse
    mem_write = 1'b1;
    mem_addr = 16'h0060;
    mem_wdata = 16'hBEEF;
    tick;
    tick;
    chk("r_pulse_we", Ram2WE, 0);
    rst = 1'b0;
    tick;
    chk("r_we", Ram2WE, 1);
    chk("r_doe", Ram2Data_oe, 0);
    chk("r_en", Ram2EN, 1);
    chk("r_stall", stall_o, 0);
    rst = 1'b1;
    mem_write = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (mem_done) done_cnt++;
    end
    chk("r_no_done", done_cnt, 0);
    chk("r_idle_oe", Ram2OE, 1);
    chk("r_idle_we", Ram2WE, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
